pmmu_ws: RTL and testbench
==========================

# pmmu_ws

Parametrised physical memory unit with programmable wait states, a busy/ready handshake and access-fault detection, intended to replace the zero-latency PMMU in the multicycle core. It holds a little-endian word-organised memory, performs RV32I byte/half/word loads and stores selected by funct3, and drives the control matrix's memory-busy input so the sequencer stalls until each access completes.

## Interface
- DATA_WIDTH, 32: data and byte-address width. Only 32 is supported for RV32I sub-word access.
- WORDS, 1024: memory depth in words. Valid byte addresses are 0 to 4*WORDS-1.
- WAIT_STATES, 2: number of stall cycles inserted per access. Legal range is 0..15.

Ports:
- clk_i, in, 1: single clock. Everything updates on the rising edge.
- reset_i, in, 1: asynchronous, active-high reset.
- funct3_i, in, 3: access size and sign selection, RV32I encoding.
- byte_addr_i, in, DATA_WIDTH: byte address.
- wd_i, in, DATA_WIDTH: store data, taken from the low bytes.
- mrd_i, in, 1: read request.
- mwr_i, in, 1: write request.
- rd_o, out, DATA_WIDTH: registered load result.
- busy_o, out, 1: access in progress. The sequencer must hold.
- rdy_o, out, 1: one-cycle completion pulse.
- fault_o, out, 1: one-cycle fault pulse, coincident with rdy_o.

## Operation
- State machine with three states: IDLE, WAIT, RESP.
- **Request acceptance**
  - A request is accepted at a rising edge while the state is IDLE or RESP and (mrd_i | mwr_i) is high.
  - On acceptance, latch funct3_i, byte_addr_i, wd_i, the read/write kind, and the fault decision.
- **Transitions**
  - Accept with WAIT_STATES=0: the access executes at the accept edge, then go to RESP.
  - Accept with WAIT_STATES>0: go to WAIT with cnt=WAIT_STATES.
  - In WAIT: decrement cnt each edge. At the edge where cnt==1, execute the access and go to RESP.
  - In RESP with no new request: go to IDLE. With a new request: accept it as above (back-to-back operation).
- **Loads** (address = latched byte address, word index = addr[31:2])
  - 000 LB: sign-extend the selected byte.
  - 100 LBU: zero-extend the selected byte.
  - 001 LH: sign-extend the selected half-word.
  - 101 LHU: zero-extend the selected half-word.
  - 010 LW: full word.
  - The byte lane is selected by addr[1:0]; the half-word lane by addr[1].
- **Stores**
  - 000 SB writes wd_i[7:0] into the byte lane only.
  - 001 SH writes wd_i[15:0] into the half-word lane only.
  - 010 SW writes the whole word.
  - Bytes outside the selected lane are unchanged.
- **Fault conditions.** Any of the following faults the access:
  - mrd_i and mwr_i both high;
  - funct3 of 011, 110 or 111;
  - funct3 of 100 or 101 on a write;
  - half-word access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - word index ≥ WORDS.
- **Faulted access**
  - Takes the same latency as a normal access.
  - Memory is not written and rd_o holds its previous value.
  - rdy_o and fault_o pulse together.
- **Writes** leave rd_o unchanged.
- **Reset**
  - reset_i asserted at any time, including mid-WAIT, forces state IDLE and cnt=0.
  - Outputs go to rd_o=0, busy_o=0, rdy_o=0, fault_o=0.
  - Any pending access is abandoned with no memory write.
  - Memory contents are not cleared.

## Timing
- Cycle numbering: the request is presented in cycle 0 and accepted at the end of cycle 0.
- busy_o is high exactly in WAIT, i.e. cycles 1..WAIT_STATES. busy_o is registered and is low in cycle 0.
- The sequencer keeps its request asserted only in cycle 0. Request inputs are ignored during WAIT.
- Latency:
  - rdy_o is high in cycle WAIT_STATES+1, the RESP state.
  - rd_o is valid from that cycle and holds until the next completed load.
- Throughput: a request presented in the RESP cycle is accepted, giving one access per WAIT_STATES+1 cycles.
- With WAIT_STATES=0:
  - busy_o never asserts.
  - rdy_o is high in cycle 1, and can stay high on consecutive cycles under back-to-back requests.
- Reset assertion clears all outputs immediately, without waiting for a clock edge. The first request can be accepted at the first edge after deassertion.

## Test plan
- **Word write/read, WAIT_STATES=2:**
  - SW 0xDEADBEEF to address 0x40, then LW 0x40.
  - Required: busy_o high in cycles 1–2, rdy_o high in cycle 3, rd_o=0xDEADBEEF, fault_o=0.
- **Sub-word stores and loads:**
  - SW 0x00000000 to 0x44, SB 0x80 to 0x45, SH 0xF123 to 0x46.
  - Required: LW 0x44 returns 0xF1238000; LB 0x45 returns 0xFFFFFF80; LBU 0x45 returns 0x00000080; LHU 0x46 returns 0x0000F123.
- **Faults:**
  - LW at 0x42, SH at 0x41, LB at 4*WORDS, and mrd_i+mwr_i together each pulse rdy_o and fault_o in cycle 3.
  - rd_o and memory remain unchanged; a follow-up LW 0x40 still returns 0xDEADBEEF.
- **Reset mid-WAIT:**
  - Start SW 0x12345678 to 0x40 and assert reset_i during cycle 1.
  - Required: all outputs are 0 immediately and the state is IDLE; a subsequent LW 0x40 returns the old value.
- **Back-to-back, WAIT_STATES=0:**
  - LW 0x40 then LW 0x44 on consecutive cycles.
  - Required: rdy_o high in cycles 1 and 2, busy_o never high, and the correct data in each cycle.
- **Maximum stalls, WAIT_STATES=15:**
  - A single LW.
  - Required: busy_o high for exactly 15 cycles, rdy_o high in cycle 16; a request asserted during WAIT is ignored.

Source files
------------

// File: rtl/pmmu_ws.sv
// Word-organised RV32I memory with WAIT_STATES stall cycles and access-fault detection; one access per WAIT_STATES+1 cycles.
// Latency: rdy_o/fault_o pulse WAIT_STATES+1 cycles after acceptance; busy_o holds the sequencer during WAIT; requests are ignored while busy.
module pmmu_ws #(
    parameter int DATA_WIDTH  = 32,
    parameter int WORDS       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] byte_addr_i,
    input  logic [DATA_WIDTH-1:0] wd_i,
    input  logic                  mrd_i,
    input  logic                  mwr_i,
    output logic [DATA_WIDTH-1:0] rd_o,
    output logic                  busy_o,
    output logic                  rdy_o,
    output logic                  fault_o
);
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int LW = AW + 2;
    localparam logic [DATA_WIDTH-1:0] WORDS_L = DATA_WIDTH'(WORDS);
    localparam logic [3:0] WS_L = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [2:0]            f3_q, f3_d;
    logic [LW-1:0]         addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;
    logic                  wr_q, wr_d;
    logic                  flt_q, flt_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic                  req, accept, new_fault;
    logic                  exec_en, ex_wr, ex_flt;
    logic [2:0]            ex_f3;
    logic [LW-1:0]         ex_addr;
    logic [DATA_WIDTH-1:0] ex_wd, word_rd, wr_word, load_val;
    logic [AW-1:0]         idx;
    logic [7:0]            byte_val;
    logic [15:0]           half_val;
    logic                  mem_we;

    function automatic logic access_fault(input logic [2:0] f3, input logic [DATA_WIDTH-1:0] a,
                                          input logic r, input logic w);
        logic f;
        f = r & w;
        case (f3)
            3'b011, 3'b110, 3'b111: f = 1'b1;
            3'b100, 3'b101:         f = f | w;
            default:                ;
        endcase
        if (f3[1:0] == 2'b01 && a[0])          f = 1'b1;
        if (f3[1:0] == 2'b10 && a[1:0] != 2'b00) f = 1'b1;
        if ({2'b00, a[DATA_WIDTH-1:2]} >= WORDS_L) f = 1'b1;
        return f;
    endfunction

    // With no wait states the access runs straight off the request inputs at the accept edge.
    always_comb begin
        req       = mrd_i | mwr_i;
        accept    = req && (state_q == S_IDLE || state_q == S_RESP);
        new_fault = access_fault(funct3_i, byte_addr_i, mrd_i, mwr_i);
        if (WAIT_STATES == 0) begin
            exec_en = accept;
            ex_f3   = funct3_i;
            ex_addr = byte_addr_i[LW-1:0];
            ex_wd   = wd_i;
            ex_wr   = mwr_i;
            ex_flt  = new_fault;
        end else begin
            exec_en = (state_q == S_WAIT) && (cnt_q == 4'd1);
            ex_f3   = f3_q;
            ex_addr = addr_q;
            ex_wd   = wd_q;
            ex_wr   = wr_q;
            ex_flt  = flt_q;
        end
    end

    always_comb begin
        idx      = ex_addr[LW-1:2];
        word_rd  = mem[idx];
        byte_val = word_rd[{ex_addr[1:0], 3'b000} +: 8];
        half_val = word_rd[{ex_addr[1], 4'b0000} +: 16];
        load_val = word_rd;
        case (ex_f3)
            3'b000:  load_val = {{(DATA_WIDTH-8){byte_val[7]}}, byte_val};
            3'b100:  load_val = {{(DATA_WIDTH-8){1'b0}}, byte_val};
            3'b001:  load_val = {{(DATA_WIDTH-16){half_val[15]}}, half_val};
            3'b101:  load_val = {{(DATA_WIDTH-16){1'b0}}, half_val};
            default: load_val = word_rd;
        endcase
        wr_word = word_rd;
        case (ex_f3)
            3'b000:  wr_word[{ex_addr[1:0], 3'b000} +: 8] = ex_wd[7:0];
            3'b001:  wr_word[{ex_addr[1], 4'b0000} +: 16] = ex_wd[15:0];
            default: wr_word = ex_wd;
        endcase
        mem_we = exec_en && ex_wr && !ex_flt && !reset_i;
        rd_d   = (exec_en && !ex_wr && !ex_flt) ? load_val : rd_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        wr_d    = wr_q;
        flt_d   = flt_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    f3_d    = funct3_i;
                    addr_d  = byte_addr_i[LW-1:0];
                    wd_d    = wd_i;
                    wr_d    = mwr_i;
                    flt_d   = new_fault;
                    cnt_d   = WS_L;
                    state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wd_q    <= '0;
            wr_q    <= 1'b0;
            flt_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            wr_q    <= wr_d;
            flt_q   <= flt_d;
            rd_q    <= rd_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[idx] <= wr_word;
    end

    assign rd_o    = rd_q;
    assign busy_o  = (state_q == S_WAIT);
    assign rdy_o   = (state_q == S_RESP);
    assign fault_o = (state_q == S_RESP) && flt_q;

endmodule

// File: tb/tb_pmmu_ws.sv
// Bench for pmmu_ws: WAIT_STATES=2, 0 and 15 instances driven by a vector table, directed sequences and a byte-level model.
module tb_pmmu_ws;
    localparam int NW = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  f3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wd = 32'd0;
    logic        mrd [3];
    logic        mwr [3];
    logic [31:0] rd_w [3];
    logic        busy_w [3];
    logic        rdy_w [3];
    logic        flt_w [3];
    logic [31:0] held [3];
    logic [7:0]  mbytes [4*NW];
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    pmmu_ws #(.DATA_WIDTH(32), .WORDS(NW), .WAIT_STATES(2)) u_ws2 (
        .clk_i(clk), .reset_i(rst), .funct3_i(f3), .byte_addr_i(addr), .wd_i(wd),
        .mrd_i(mrd[0]), .mwr_i(mwr[0]), .rd_o(rd_w[0]), .busy_o(busy_w[0]),
        .rdy_o(rdy_w[0]), .fault_o(flt_w[0]));
    pmmu_ws #(.DATA_WIDTH(32), .WORDS(NW), .WAIT_STATES(0)) u_ws0 (
        .clk_i(clk), .reset_i(rst), .funct3_i(f3), .byte_addr_i(addr), .wd_i(wd),
        .mrd_i(mrd[1]), .mwr_i(mwr[1]), .rd_o(rd_w[1]), .busy_o(busy_w[1]),
        .rdy_o(rdy_w[1]), .fault_o(flt_w[1]));
    pmmu_ws #(.DATA_WIDTH(32), .WORDS(NW), .WAIT_STATES(15)) u_ws15 (
        .clk_i(clk), .reset_i(rst), .funct3_i(f3), .byte_addr_i(addr), .wd_i(wd),
        .mrd_i(mrd[2]), .mwr_i(mwr[2]), .rd_o(rd_w[2]), .busy_o(busy_w[2]),
        .rdy_o(rdy_w[2]), .fault_o(flt_w[2]));

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        r;
        logic        w;
        logic [31:0] data;
        logic        flt;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete access on instance k; inj>0 drives a stray store during that WAIT cycle.
    task automatic access(input int k, input int ws, input string nm, input logic [2:0] fv,
                          input logic [31:0] a, input logic [31:0] wdv, input logic r,
                          input logic w, input logic [31:0] data, input logic flt, input int inj);
        f3 = fv; addr = a; wd = wdv; mrd[k] = r; mwr[k] = w;
        chk({nm, "_busy_c0"}, {31'd0, busy_w[k]}, 32'd0);
        tick();
        mrd[k] = 1'b0; mwr[k] = 1'b0;
        if (r && !w && !flt) held[k] = data;
        for (int c = 1; c <= ws; c++) begin
            chk({nm, "_busy_w"}, {31'd0, busy_w[k]}, 32'd1);
            chk({nm, "_rdy_w"}, {31'd0, rdy_w[k]}, 32'd0);
            mwr[k] = (c == inj);
            if (c == inj) begin
                f3 = 3'd2; addr = 32'h40; wd = 32'h0BADF00D;
            end
            tick();
            mwr[k] = 1'b0;
        end
        chk({nm, "_rdy"}, {31'd0, rdy_w[k]}, 32'd1);
        chk({nm, "_fault"}, {31'd0, flt_w[k]}, {31'd0, flt});
        chk({nm, "_busy_r"}, {31'd0, busy_w[k]}, 32'd0);
        chk({nm, "_rd"}, rd_w[k], held[k]);
        tick();
        chk({nm, "_rdy_off"}, {31'd0, rdy_w[k]}, 32'd0);
        chk({nm, "_flt_off"}, {31'd0, flt_w[k]}, 32'd0);
    endtask

    function automatic logic model_fault(input logic [2:0] fv, input logic [31:0] a,
                                         input logic r, input logic w);
        int  sz;
        logic legal;
        sz    = 1 << fv[1:0];
        legal = (fv == 3'd0 || fv == 3'd1 || fv == 3'd2 || ((fv == 3'd4 || fv == 3'd5) && !w));
        return (r && w) || !legal || ((a % sz) != 0) || ((a / 4) >= NW);
    endfunction

    // Zero-wait instance: every call is one cycle, so consecutive calls are back-to-back requests.
    task automatic step0(input string nm, input logic [2:0] fv, input logic [31:0] a,
                         input logic [31:0] wdv, input logic r, input logic w);
        logic        req, flt;
        int          sz;
        logic [31:0] v;
        req = r | w;
        flt = model_fault(fv, a, r, w);
        sz  = 1 << fv[1:0];
        if (req && !flt) begin
            if (w) begin
                for (int i = 0; i < sz; i++) mbytes[a + i] = 8'(wdv >> (8 * i));
            end else begin
                v = 32'd0;
                for (int i = 0; i < sz; i++) v = v | (32'(mbytes[a + i]) << (8 * i));
                if (!fv[2] && sz == 1 && v[7])  v = v | 32'hFFFFFF00;
                if (!fv[2] && sz == 2 && v[15]) v = v | 32'hFFFF0000;
                held[1] = v;
            end
        end
        f3 = fv; addr = a; wd = wdv; mrd[1] = r; mwr[1] = w;
        tick();
        mrd[1] = 1'b0; mwr[1] = 1'b0;
        chk({nm, "_rdy"}, {31'd0, rdy_w[1]}, {31'd0, req});
        chk({nm, "_fault"}, {31'd0, flt_w[1]}, {31'd0, req && flt});
        chk({nm, "_busy"}, {31'd0, busy_w[1]}, 32'd0);
        chk({nm, "_rd"}, rd_w[1], held[1]);
    endtask

    initial begin
        logic [2:0]  rf3;
        logic [31:0] ra, rwd;
        int          sel;

        for (int k = 0; k < 3; k++) begin
            mrd[k] = 1'b0; mwr[k] = 1'b0; held[k] = 32'd0;
        end

        tbl[0]  = '{"sw40",    3'd2, 32'h40,  32'hDEADBEEF, 1'b0, 1'b1, 32'h0,        1'b0};
        tbl[1]  = '{"lw40",    3'd2, 32'h40,  32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{"sw44",    3'd2, 32'h44,  32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
        tbl[3]  = '{"sb45",    3'd0, 32'h45,  32'hAAAAAA80, 1'b0, 1'b1, 32'h0,        1'b0};
        tbl[4]  = '{"sh46",    3'd1, 32'h46,  32'h5555F123, 1'b0, 1'b1, 32'h0,        1'b0};
        tbl[5]  = '{"lw44",    3'd2, 32'h44,  32'h0,        1'b1, 1'b0, 32'hF1238000, 1'b0};
        tbl[6]  = '{"lb45",    3'd0, 32'h45,  32'h0,        1'b1, 1'b0, 32'hFFFFFF80, 1'b0};
        tbl[7]  = '{"lbu45",   3'd4, 32'h45,  32'h0,        1'b1, 1'b0, 32'h00000080, 1'b0};
        tbl[8]  = '{"lhu46",   3'd5, 32'h46,  32'h0,        1'b1, 1'b0, 32'h0000F123, 1'b0};
        tbl[9]  = '{"lh46",    3'd1, 32'h46,  32'h0,        1'b1, 1'b0, 32'hFFFFF123, 1'b0};
        tbl[10] = '{"f_lw42",  3'd2, 32'h42,  32'h0,        1'b1, 1'b0, 32'h0,        1'b1};
        tbl[11] = '{"f_sh41",  3'd1, 32'h41,  32'h0000FFFF, 1'b0, 1'b1, 32'h0,        1'b1};
        tbl[12] = '{"f_lbtop", 3'd0, 32'h100, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1};
        tbl[13] = '{"f_rw",    3'd2, 32'h40,  32'h11111111, 1'b1, 1'b1, 32'h0,        1'b1};
        tbl[14] = '{"f_sbu",   3'd4, 32'h40,  32'h22222222, 1'b0, 1'b1, 32'h0,        1'b1};
        tbl[15] = '{"f_f3_3",  3'd3, 32'h40,  32'h0,        1'b1, 1'b0, 32'h0,        1'b1};
        tbl[16] = '{"lw40b",   3'd2, 32'h40,  32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1'b0};
        tbl[17] = '{"lb40",    3'd0, 32'h40,  32'h0,        1'b1, 1'b0, 32'hFFFFFFEF, 1'b0};
        tbl[18] = '{"lbu43",   3'd4, 32'h43,  32'h0,        1'b1, 1'b0, 32'h000000DE, 1'b0};
        tbl[19] = '{"lhu42",   3'd5, 32'h42,  32'h0,        1'b1, 1'b0, 32'h0000DEAD, 1'b0};

        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_rd", rd_w[k], 32'd0);
            chk("rst_busy", {31'd0, busy_w[k]}, 32'd0);
            chk("rst_rdy", {31'd0, rdy_w[k]}, 32'd0);
            chk("rst_fault", {31'd0, flt_w[k]}, 32'd0);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 20; i++)
            access(0, 2, tbl[i].name, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].r, tbl[i].w,
                   tbl[i].data, tbl[i].flt, 0);

        // Reset arriving in the first WAIT cycle abandons the pending store.
        f3 = 3'd2; addr = 32'h40; wd = 32'h12345678; mwr[0] = 1'b1;
        tick();
        mwr[0] = 1'b0;
        chk("midrst_busy_pre", {31'd0, busy_w[0]}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_rd", rd_w[0], 32'd0);
        chk("midrst_busy", {31'd0, busy_w[0]}, 32'd0);
        chk("midrst_rdy", {31'd0, rdy_w[0]}, 32'd0);
        chk("midrst_fault", {31'd0, flt_w[0]}, 32'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) held[k] = 32'd0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("midrst_idle_rdy", {31'd0, rdy_w[0]}, 32'd0);
            chk("midrst_idle_busy", {31'd0, busy_w[0]}, 32'd0);
        end
        access(0, 2, "midrst_lw40", 3'd2, 32'h40, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 0);

        for (int i = 0; i < NW; i++) step0("init", 3'd2, 32'(4 * i), $urandom, 1'b0, 1'b1);
        step0("b2b_sw40", 3'd2, 32'h40, 32'hDEADBEEF, 1'b0, 1'b1);
        step0("b2b_sw44", 3'd2, 32'h44, 32'hF1238000, 1'b0, 1'b1);
        step0("b2b_lw40", 3'd2, 32'h40, 32'h0, 1'b1, 1'b0);
        chk("b2b_lw40_data", rd_w[1], 32'hDEADBEEF);
        step0("b2b_lw44", 3'd2, 32'h44, 32'h0, 1'b1, 1'b0);
        chk("b2b_lw44_data", rd_w[1], 32'hF1238000);
        step0("b2b_idle", 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            rf3  = 3'($urandom_range(0, 7));
            ra   = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 4 * NW + 15));
            rwd  = $urandom;
            sel  = $urandom_range(0, 7);
            step0("rnd", rf3, ra, rwd, sel <= 2 || sel == 6, (sel >= 3 && sel <= 5) || sel == 6);
        end

        access(2, 15, "ws15_sw", 3'd2, 32'h40, 32'hCAFEF00D, 1'b0, 1'b1, 32'h0, 1'b0, 0);
        access(2, 15, "ws15_lw", 3'd2, 32'h40, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 5);
        access(2, 15, "ws15_lw2", 3'd2, 32'h40, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
